// File: rtl/filtragem_peso.sv
// filtragem_peso: selects a product weight, averages the last four samples,
// subtracts a captured tare and registers the saturated net weight.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   produto        product select (0 none, 1 banana, 2 maracuja, 3 tangerina)
//   peso_banana    gross banana weight
//   peso_maracuja  gross maracuja weight
//   peso_tangerina gross tangerina weight
//   tara           tare request, captured on its rising edge
//   peso_liq       registered net filtered weight, saturated at zero
module filtragem_peso (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  produto,
    input  logic [10:0] peso_banana,
    input  logic [10:0] peso_maracuja,
    input  logic [10:0] peso_tangerina,
    input  logic        tara,
    output logic [10:0] peso_liq
);
    logic [10:0] s [4];
    logic [1:0]  produto_d;
    logic        tara_d;
    logic [10:0] tare_reg;
    logic [10:0] gross;
    logic [12:0] sum;
    logic [10:0] filt;
    logic [11:0] diff;

    always_comb begin
        gross = produto == 2'd0 ? 11'd0 :
                produto == 2'd1 ? peso_banana :
                produto == 2'd2 ? peso_maracuja : peso_tangerina;
        sum   = {2'b0, s[0]} + {2'b0, s[1]} + {2'b0, s[2]} + {2'b0, s[3]};
        filt  = sum[12:2];
        // extra bit exposes a negative result as bit 11 for saturation
        diff  = {1'b0, filt} - {1'b0, tare_reg};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) s[i] <= '0;
            produto_d <= '0;
            tara_d    <= 1'b0;
            tare_reg  <= '0;
            peso_liq  <= '0;
        end else begin
            // a product change refills the whole window so no stale samples mix in
            if (produto != produto_d) begin
                for (int i = 0; i < 4; i++) s[i] <= gross;
            end else begin
                s[0] <= gross;
                for (int i = 1; i < 4; i++) s[i] <= s[i-1];
            end
            produto_d <= produto;
            tara_d    <= tara;
            if (tara && !tara_d) tare_reg <= filt;
            peso_liq  <= diff[11] ? 11'd0 : diff[10:0];
        end
    end
endmodule

// File: tb/tb_filtragem_peso.sv
// tb_filtragem_peso: directed stimulus with a behavioural reference model.
module tb_filtragem_peso;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  produto = 2'd2;
    logic [10:0] peso_banana = 11'd100;
    logic [10:0] peso_maracuja = 11'd200;
    logic [10:0] peso_tangerina = 11'd300;
    logic        tara = 1'b1;
    logic [10:0] peso_liq;

    int passed = 0;
    int total = 0;

    filtragem_peso dut (
        .clk(clk), .rst(rst), .produto(produto),
        .peso_banana(peso_banana), .peso_maracuja(peso_maracuja),
        .peso_tangerina(peso_tangerina), .tara(tara), .peso_liq(peso_liq)
    );

    always #5 clk = ~clk;

    // reference model: a window of the four newest samples, averaged with
    // integer division, and a net weight clamped at zero
    int h [4];
    int m_prod_d, m_tare, m_peso, m_avg, m_g, m_net;
    bit m_tara_d;

    function automatic int gross_of(int p);
        return p == 0 ? 0 : p == 1 ? int'(peso_banana) :
               p == 2 ? int'(peso_maracuja) : int'(peso_tangerina);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) h[i] = 0;
            m_prod_d = 0; m_tare = 0; m_peso = 0; m_tara_d = 0;
        end else begin
            m_avg = (h[0] + h[1] + h[2] + h[3]) / 4;
            m_g   = gross_of(int'(produto));
            m_net = m_avg - m_tare;
            m_peso = m_net < 0 ? 0 : m_net;
            if (tara && !m_tara_d) m_tare = m_avg;
            m_tara_d = tara;
            if (int'(produto) != m_prod_d) begin
                for (int i = 0; i < 4; i++) h[i] = m_g;
            end else begin
                for (int i = 3; i > 0; i--) h[i] = h[i-1];
                h[0] = m_g;
            end
            m_prod_d = int'(produto);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if (int'(peso_liq) == m_peso) passed++;
            else $display("FAIL model_cmp t=%0t peso_liq=%0d expected=%0d", $time, peso_liq, m_peso);
        end
    end

    task automatic chk(input string name, input int exp);
        total++;
        if (int'(peso_liq) == exp) passed++;
        else $display("FAIL %s peso_liq=%0d expected=%0d", name, peso_liq, exp);
        total++;
        if (m_peso == exp) passed++;
        else $display("FAIL %s_model model=%0d expected=%0d", name, m_peso, exp);
    endtask

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #12;
        chk("reset_state", 0);
        @(negedge clk) rst = 1'b0;
        edges(1); chk("tare_after_reset_e1", 0);
        edges(1); chk("tare_after_reset_e2", 200);
        edges(1); chk("tare_after_reset_e3", 200);
        tara = 1'b0;
        produto = 2'd1;
        edges(2); chk("switch_to_banana", 100);
        produto = 2'd3;
        edges(1); chk("switch_edge_old", 100);
        edges(1); chk("switch_to_tangerina", 300);
        tara = 1'b1;
        edges(1); chk("tare_capture_edge", 300);
        edges(1); chk("tare_held_net_zero", 0);
        tara = 1'b0;
        edges(1); chk("tare_steady", 0);
        produto = 2'd1;
        edges(2); chk("tare_saturate", 0);
        peso_tangerina = 11'd350;
        produto = 2'd3;
        edges(2); chk("tare_subtract", 50);
        edges(2);
        #2 rst = 1'b1;
        #1 chk("async_reset", 0);
        @(negedge clk) rst = 1'b0;
        produto = 2'd1;
        peso_banana = 11'd0;
        edges(2); chk("avg_base", 0);
        peso_banana = 11'd400;
        edges(1); chk("avg_e1", 0);
        edges(1); chk("avg_e2", 100);
        edges(1); chk("avg_e3", 200);
        edges(1); chk("avg_e4", 300);
        edges(1); chk("avg_e5", 400);
        peso_banana = 11'd2047; peso_maracuja = 11'd2047; peso_tangerina = 11'd2047;
        produto = 2'd2;
        edges(2); chk("limit_max", 2047);
        edges(3); chk("limit_max_steady", 2047);
        produto = 2'd0;
        edges(1); chk("limit_zero_edge", 2047);
        edges(1); chk("limit_zero", 0);
        peso_banana = 11'd800; peso_maracuja = 11'd1000;
        produto = 2'd1;
        edges(3); chk("pre_combo", 800);
        produto = 2'd2;
        tara = 1'b1;
        edges(1); chk("combo_edge", 800);
        edges(1); chk("combo_net", 200);
        tara = 1'b0;
        peso_maracuja = 11'd1003;
        edges(5); chk("truncate_settle", 203);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
